// File: rtl/fb_port_arbiter.sv
// Single-port frame buffer arbiter: display reads always win; buffered pixel writes and
// the screen-clear engine share whatever cycles the display leaves idle.
module fb_port_arbiter #(
    parameter int FB_WORDS   = 76800,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [11:0]       disp_rdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [11:0]       wr_data,
    input  logic              clr_start,
    input  logic [11:0]       clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              oob_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
    localparam logic [ADDR_W-1:0] FB_LIMIT  = ADDR_W'(FB_WORDS);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [11:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [11:0]       clr_color_q, clr_color_nxt;
    logic              clr_done_nxt;
    logic              push, pop, fill_we, fifo_empty, head_oob;

    assign fifo_empty = (count == '0);
    assign head_oob   = (fifo_addr[rd_ptr] >= FB_LIMIT);
    assign wr_ready   = reset_n && (count < DEPTH_C) && (state == ST_IDLE);
    assign push       = wr_valid && wr_ready;
    assign clr_busy   = (state != ST_IDLE);
    assign disp_rdata = mem_rdata;

    // Port grant: display, then queued writes, then clear fill
    always_comb begin
        mem_addr  = disp_addr;
        mem_we    = 1'b0;
        mem_wdata = fifo_data[rd_ptr];
        pop       = 1'b0;
        fill_we   = 1'b0;
        if (disp_req) begin
            mem_addr = disp_addr;
        end else if ((state == ST_IDLE || state == ST_DRAIN) && !fifo_empty) begin
            pop       = 1'b1;
            mem_addr  = fifo_addr[rd_ptr];
            mem_wdata = fifo_data[rd_ptr];
            mem_we    = !head_oob;
        end else if (state == ST_FILL) begin
            fill_we   = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = clr_color_q;
            mem_we    = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        clr_cnt_nxt   = clr_cnt;
        clr_color_nxt = clr_color_q;
        clr_done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_start) begin
                    clr_color_nxt = clr_color;
                    clr_cnt_nxt   = '0;
                    state_nxt     = fifo_empty ? ST_FILL : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_we) begin
                    if (clr_cnt == LAST_ADDR) begin
                        clr_cnt_nxt  = '0;
                        state_nxt    = ST_IDLE;
                        clr_done_nxt = 1'b1;
                    end else begin
                        clr_cnt_nxt = clr_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state: FSM, clear counter, FIFO pointers and flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            clr_cnt     <= '0;
            clr_color_q <= '0;
            clr_done    <= 1'b0;
            oob_err     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            state       <= state_nxt;
            clr_cnt     <= clr_cnt_nxt;
            clr_color_q <= clr_color_nxt;
            clr_done    <= clr_done_nxt;
            if (pop && head_oob)
                oob_err <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Write FIFO storage is data only and needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomised and directed bench for fb_port_arbiter against a queue-based behavioural
// model of the grant rules, FIFO and clear sequence, plus a BRAM model.
module tb_fb_port_arbiter;

    localparam int FBW = 76800;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        disp_req;
    logic [16:0] disp_addr;
    logic [11:0] disp_rdata;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic        oob_err;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    fb_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .clr_done(clr_done), .oob_err(oob_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // BRAM: synchronous read, latency 1
    logic [11:0] bram [0:FBW-1];
    initial begin
        for (int i = 0; i < FBW; i++) bram[i] <= 12'h000;
        mem_rdata <= 12'h000;
    end
    always @(posedge clk) begin
        if (mem_we && mem_addr < FBW) bram[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_addr < FBW) ? bram[mem_addr] : 12'h000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model and per-cycle compare
    logic [11:0] exp_mem [0:FBW-1];
    logic [28:0] mq [$];
    int          m_mode;       // 0 idle, 1 drain, 2 fill
    int          m_cnt;
    logic [11:0] m_color;
    bit          m_done, m_oob, prev_req;
    logic [11:0] prev_rd;

    initial begin
        logic        e_ready, e_we, popped, done_n;
        logic [16:0] e_addr;
        logic [11:0] e_wdata;
        logic [28:0] head;
        int          sz;
        for (int i = 0; i < FBW; i++) exp_mem[i] = 12'h000;
        m_mode = 0; m_cnt = 0; m_color = 0; m_done = 0; m_oob = 0; prev_req = 0; prev_rd = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mq.delete();
                m_mode = 0; m_cnt = 0; m_color = 0; m_done = 0; m_oob = 0; prev_req = 0;
                chk("rst_wr_ready", wr_ready, 0);
                chk("rst_clr_busy", clr_busy, 0);
                chk("rst_clr_done", clr_done, 0);
                chk("rst_oob_err", oob_err, 0);
                chk("rst_mem_we", mem_we, 0);
            end else begin
                sz = mq.size();
                e_ready = (sz < 4) && (m_mode == 0);
                e_we = 0; e_addr = disp_addr; e_wdata = 0; popped = 0;
                if (!disp_req && m_mode != 2 && sz > 0) begin
                    head = mq[0];
                    popped = 1;
                    e_addr = head[28:12];
                    e_wdata = head[11:0];
                    e_we = (head[28:12] < FBW);
                end else if (!disp_req && m_mode == 2) begin
                    e_addr = 17'(m_cnt);
                    e_wdata = m_color;
                    e_we = 1;
                end
                chk("mem_we", mem_we, e_we);
                if (e_we) begin
                    chk("mem_addr_wr", mem_addr, e_addr);
                    chk("mem_wdata", mem_wdata, e_wdata);
                end else if (disp_req) begin
                    chk("mem_addr_rd", mem_addr, disp_addr);
                end
                chk("wr_ready", wr_ready, e_ready);
                chk("clr_busy", clr_busy, m_mode != 0);
                chk("clr_done", clr_done, m_done);
                chk("oob_err", oob_err, m_oob);
                if (prev_req) chk("disp_rdata", disp_rdata, prev_rd);
                prev_req = disp_req && (disp_addr < FBW);
                if (prev_req) prev_rd = exp_mem[disp_addr];

                if (popped) begin
                    head = mq.pop_front();
                    if (head[28:12] >= FBW) m_oob = 1;
                    else exp_mem[head[28:12]] = head[11:0];
                end
                if (wr_valid && e_ready) mq.push_back({wr_addr, wr_data});
                done_n = 0;
                case (m_mode)
                    0: if (clr_start) begin
                        m_color = clr_color;
                        m_cnt = 0;
                        m_mode = (sz == 0) ? 2 : 1;
                    end
                    1: if (sz == 0) begin
                        m_mode = 2;
                        m_cnt = 0;
                    end
                    default: if (!disp_req) begin
                        exp_mem[m_cnt] = m_color;
                        if (m_cnt == FBW - 1) begin
                            m_cnt = 0;
                            m_mode = 0;
                            done_n = 1;
                        end else begin
                            m_cnt++;
                        end
                    end
                endcase
                m_done = done_n;
            end
        end
    end

    task automatic step(output bit acc);
        @(negedge clk);
        acc = wr_valid && wr_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        bit a;
        disp_req = 0; wr_valid = 0; clr_start = 0;
        for (int i = 0; i < n; i++) step(a);
    endtask

    initial begin
        bit acc, done_seen;
        int k, busy;
        reset_n = 0; disp_req = 0; disp_addr = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
        clr_start = 0; clr_color = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        // Random traffic, in-range addresses, no clears
        for (int i = 0; i < 3000; i++) begin
            disp_req  = 1'($urandom_range(0, 1));
            disp_addr = 17'($urandom_range(0, 1023));
            wr_valid  = ($urandom_range(0, 2) != 0);
            wr_addr   = 17'($urandom_range(0, 1023));
            wr_data   = 12'($urandom);
            step(acc);
        end
        idle_cycles(10);

        // Display holds the port for 640 cycles; FIFO fills and stalls
        k = 0;
        disp_req = 1;
        for (int i = 0; i < 640; i++) begin
            disp_addr = 17'($urandom_range(0, 1023));
            wr_valid = 1; wr_addr = 17'(200 + k); wr_data = 12'(12'h300 + k);
            step(acc);
            if (acc) k++;
        end
        @(negedge clk);
        chk("t1_full_ready", wr_ready, 0);
        chk("t1_accepted", k, 4);
        @(posedge clk); #1;
        idle_cycles(10);

        // Alternating display requests with 8 queued writes
        k = 0;
        for (int c = 0; c < 200 && k < 8; c++) begin
            disp_req = c[0];
            disp_addr = 17'($urandom_range(0, 1023));
            wr_valid = 1; wr_addr = 17'(100 + k); wr_data = 12'hF00;
            step(acc);
            if (acc) k++;
        end
        idle_cycles(12);
        chk("t2_accepted", k, 8);
        for (int i = 0; i < 8; i++) chk("t2_bram_F00", bram[100 + i], 12'hF00);

        // Three queued writes, then a full clear; a write offered meanwhile lands afterwards
        disp_req = 1; disp_addr = 0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_addr = 17'(100 + i); wr_data = 12'(12'hA00 + i);
            step(acc);
        end
        wr_valid = 0; clr_start = 1; clr_color = 12'h0F0;
        step(acc);
        clr_start = 0; disp_req = 0;
        wr_valid = 1; wr_addr = 17'd5; wr_data = 12'h123;
        busy = 0; done_seen = 0;
        for (int i = 0; i < 80000 && !done_seen; i++) begin
            clr_start = (i == 1000);
            clr_color = (i == 1000) ? 12'hFFF : 12'h0F0;
            @(negedge clk);
            if (clr_busy) busy++;
            if (clr_done) done_seen = 1;
            @(posedge clk); #1;
        end
        wr_valid = 0; clr_start = 0;
        chk("t5_clr_done_seen", done_seen, 1);
        // 4 drain cycles (3 pops + empty check) plus one fill cycle per word
        chk("t5_busy_cycles", busy, 76804);
        idle_cycles(5);
        chk("t4_bram_first", bram[0], 12'h0F0);
        chk("t4_bram_last", bram[FBW - 1], 12'h0F0);
        chk("t5_bram_100", bram[100], 12'h0F0);
        chk("t5_bram_102", bram[102], 12'h0F0);
        chk("t5_late_write", bram[5], 12'h123);

        // Out-of-range write, then reset in the middle of a fill
        disp_req = 0; wr_valid = 1; wr_addr = 17'd76800; wr_data = 12'h777;
        step(acc);
        wr_valid = 0;
        idle_cycles(3);
        chk("t6_oob_set", oob_err, 1);
        clr_start = 1; clr_color = 12'h555;
        step(acc);
        clr_start = 0;
        for (int i = 0; i < 200; i++) step(acc);
        reset_n = 0;
        @(negedge clk);
        chk("t6_rst_busy", clr_busy, 0);
        chk("t6_rst_oob", oob_err, 0);
        chk("t6_rst_ready", wr_ready, 0);
        wr_valid = 1; wr_addr = 17'd7; wr_data = 12'h321;
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        chk("t6_post_ready", wr_ready, 1);
        chk("t6_post_busy", clr_busy, 0);
        @(posedge clk); #1;
        idle_cycles(5);
        chk("t6_post_write", bram[7], 12'h321);
        chk("t6_partial_fill", bram[0], 12'h555);
        chk("t6_untouched", bram[1000], 12'h0F0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
